// File: rtl/ncl_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module : ncl_sync_pkg
// Desc   : Shared types, dual-rail codes and pair classifiers for the bridge.
// Rev    : 1.0
// ============================================================================
package ncl_sync_pkg;

  typedef enum logic [1:0] {
    FLUSH     = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_NULL = 2'd2
  } state_t;

  localparam logic [1:0] NULL_DR  = 2'b00;
  localparam logic [1:0] TRUE_DR  = 2'b10;
  localparam logic [1:0] FALSE_DR = 2'b01;
  localparam logic [1:0] ILL_DR   = 2'b11;

  function automatic logic is_data(input logic [1:0] pair);
    return (pair == TRUE_DR) || (pair == FALSE_DR);
  endfunction

  function automatic logic is_null(input logic [1:0] pair);
    return (pair == NULL_DR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_sync_bridge_dr_sync.sv
`default_nettype none
// ============================================================================
// Module : ncl_dr_sync
// Desc   : Synchronizer chain for one dual-rail pair plus stability filter.
// Rev    : 1.0
// ============================================================================
module ncl_dr_sync
  import ncl_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dr_in,
  output logic [1:0] sample,
  output logic       stable
);

  logic [2*SYNC_STAGES-1:0] r_chain;
  logic [1:0]               r_prev;
  logic [SYNC_STAGES:0]     r_fill;

  // r_fill tracks how far real samples have propagated; the reset-cleared
  // chain must not masquerade as an observed NULL wavefront.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {SYNC_STAGES{NULL_DR}};
      r_prev  <= NULL_DR;
      r_fill  <= '0;
    end else begin
      r_chain <= {r_chain[2*SYNC_STAGES-3:0], dr_in};
      r_prev  <= r_chain[2*SYNC_STAGES-1 -: 2];
      r_fill  <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sample = r_chain[2*SYNC_STAGES-1 -: 2];
  assign stable = r_fill[SYNC_STAGES] && (sample == r_prev);

endmodule
`default_nettype wire

// File: rtl/ncl_sync_bridge.sv
`default_nettype none
// ============================================================================
// Module : ncl_sync_bridge
// Desc   : NCL dual-rail Rc/Rm to clocked valid/ready bridge with 4-phase ack.
// Rev    : 1.0
// ============================================================================
module ncl_sync_bridge
  import ncl_sync_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int NULL_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rc,
  input  logic [1:0] rm,
  output logic       ack_out,
  output logic       out_valid,
  output logic       out_rc,
  output logic       out_rm,
  input  logic       out_ready,
  output logic       err_illegal,
  output logic       err_timeout,
  input  logic       err_clr
);

  localparam int                 c_cnt_w   = $clog2(NULL_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(NULL_TIMEOUT);

  logic [1:0]         w_rc_smp;
  logic [1:0]         w_rm_smp;
  logic               w_rc_stable;
  logic               w_rm_stable;
  logic               w_stable;
  logic               w_all_data;
  logic               w_all_null;
  logic               w_illegal;
  logic               w_free;
  logic               w_capture;
  logic               w_to_hit;
  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;

  ncl_dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rc (
    .clk    (clk),
    .rst    (rst),
    .dr_in  (rc),
    .sample (w_rc_smp),
    .stable (w_rc_stable)
  );

  ncl_dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rm (
    .clk    (clk),
    .rst    (rst),
    .dr_in  (rm),
    .sample (w_rm_smp),
    .stable (w_rm_stable)
  );

  assign w_stable   = w_rc_stable && w_rm_stable;
  assign w_all_data = w_stable && is_data(w_rc_smp) && is_data(w_rm_smp);
  assign w_all_null = w_stable && is_null(w_rc_smp) && is_null(w_rm_smp);
  assign w_illegal  = (w_rc_smp == ILL_DR) || (w_rm_smp == ILL_DR);

  // The single output slot is free if empty or being drained this very edge.
  assign w_free    = !out_valid || out_ready;
  assign w_capture = (r_state == WAIT_DATA) && w_all_data && w_free;
  assign w_to_hit  = (r_state == WAIT_NULL) && !w_all_null &&
                     (r_cnt == c_timeout - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FLUSH;
      ack_out   <= 1'b1;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_rc    <= 1'b0;
      out_rm    <= 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (w_all_null) begin
            r_state <= WAIT_DATA;
            ack_out <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (w_capture) begin
            r_state <= WAIT_NULL;
            ack_out <= 1'b1;
            r_cnt   <= '0;
          end
        end
        WAIT_NULL: begin
          if (w_all_null) begin
            r_state <= WAIT_DATA;
            ack_out <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt != c_timeout) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= FLUSH;
          ack_out <= 1'b1;
        end
      endcase

      if (w_capture) begin
        out_valid <= 1'b1;
        out_rc    <= (w_rc_smp == TRUE_DR);
        out_rm    <= (w_rm_smp == TRUE_DR);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky flags: a new event on the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (w_illegal)    err_illegal <= 1'b1;
      else if (err_clr) err_illegal <= 1'b0;

      if (w_to_hit)     err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ncl_sync_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_ncl_sync_bridge
// Desc   : Scoreboard bench: upstream NCL stage model drives tokens, monitor checks.
// Rev    : 1.0
// ============================================================================
module tb_ncl_sync_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rc = 2'b00;
  logic [1:0] rm = 2'b00;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       ack_out, out_valid, out_rc, out_rm, err_illegal, err_timeout;

  int         vectors = 0;
  int         miscompares = 0;
  int         sink_mode = 1;   // 0 random, 1 hold low, 2 hold high
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  ncl_sync_bridge #(.SYNC_STAGES(2), .NULL_TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .rc          (rc),
    .rm          (rm),
    .ack_out     (ack_out),
    .out_valid   (out_valid),
    .out_rc      (out_rc),
    .out_rm      (out_rm),
    .out_ready   (out_ready),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  function automatic logic [1:0] enc(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic val, input int budget, input string name);
    int n = 0;
    while (ack_out !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ack_out !== val) begin
      miscompares++;
      $display("FAIL %s: ack_out=%b after %0d cycles, expected %b", name, ack_out, n, val);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: out_valid=%b after %0d cycles, expected 1", name, out_valid, n);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 8'(exp_q.size()), 8'd0);
  endtask

  // Upstream stage: one pair goes DATA first, the other follows after a skew,
  // optionally preceded by a one-cycle glitch and a NULL gap.
  task automatic apply_data(input logic rb, input logic mb, input bit rc_first,
                            input int skew, input bit glitch);
    wait_ack(1'b0, 2000, "req_data");
    if (rc_first) rc = enc(rb); else rm = enc(mb);
    if (glitch) begin
      tick(1);
      if (rc_first) rm = enc(!mb); else rc = enc(!rb);
      tick(1);
      if (rc_first) rm = 2'b00; else rc = 2'b00;
      tick(1);
    end
    tick(skew);
    if (rc_first) rm = enc(mb); else rc = enc(rb);
    exp_q.push_back({rb, mb});
  endtask

  task automatic finish_token(input bit rc_first, input int skew);
    wait_ack(1'b1, 3000, "ack_data");
    tick(1);
    if (rc_first) rc = 2'b00; else rm = 2'b00;
    tick(skew);
    rc = 2'b00;
    rm = 2'b00;
  endtask

  // Monitor / sink: sets ready for the coming edge, then scores any accept.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sink_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
      else                out_ready = (sink_mode == 2);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL token_unexpected: got %b%b expected none at %0t", out_rc, out_rm, $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("token", {6'b0, out_rc, out_rm}, {6'b0, e});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tick(3);
    check("reset_state", {2'b0, ack_out, out_valid, out_rc, out_rm, err_illegal, err_timeout},
          8'b0010_0000);
    rst = 1'b0;
    wait_ack(1'b0, 20, "flush_exit");

    // Basic token rc=TRUE, rm=FALSE
    sink_mode = 2;
    apply_data(1'b1, 1'b0, 1'b1, 0, 1'b0);
    wait_valid(20, "basic_valid");
    check("basic_ack_high", {7'b0, ack_out}, 8'd1);
    finish_token(1'b1, 0);

    // Backpressure: second token must wait for the slot
    sink_mode = 1;
    apply_data(1'b0, 1'b1, 1'b1, 0, 1'b0);
    finish_token(1'b1, 0);
    apply_data(1'b1, 1'b1, 1'b0, 0, 1'b0);
    tick(12);
    check("bp_hold", {4'b0, ack_out, out_valid, out_rc, out_rm}, 8'b0000_0101);
    sink_mode = 2;
    tick(1);
    check("bp_swap", {4'b0, ack_out, out_valid, out_rc, out_rm}, 8'b0000_1111);
    finish_token(1'b0, 0);

    // Skew and glitch: no capture until both pairs are genuinely DATA
    wait_ack(1'b0, 50, "skew_req");
    rc = enc(1'b1);
    tick(5);
    check("skew_partial", {6'b0, ack_out, out_valid}, 8'd0);
    rm = enc(1'b1);
    tick(1);
    rm = 2'b00;
    tick(6);
    check("skew_glitch", {6'b0, ack_out, out_valid}, 8'd0);
    rm = enc(1'b0);
    exp_q.push_back(2'b10);
    finish_token(1'b1, 2);
    wait_drain(50, "skew_drain");

    // Illegal encoding
    wait_ack(1'b0, 50, "ill_req");
    rc = 2'b11;
    tick(4);
    rc = 2'b00;
    tick(8);
    check("illegal_flag", {5'b0, err_illegal, out_valid, ack_out}, 8'b0000_0100);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("illegal_clr", {7'b0, err_illegal}, 8'd0);

    // Randomized traffic with random backpressure
    sink_mode = 0;
    for (int i = 0; i < 30; i++) begin
      apply_data(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) == 0));
      finish_token(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
    sink_mode = 2;
    wait_drain(200, "random_drain");
    check("random_no_err", {6'b0, err_illegal, err_timeout}, 8'd0);

    // NULL timeout: DATA held past the limit
    wait_ack(1'b0, 50, "to_req");
    rc = enc(1'b0);
    rm = enc(1'b1);
    exp_q.push_back(2'b01);
    wait_valid(20, "to_valid");
    tick(254);
    check("to_before", {6'b0, ack_out, err_timeout}, 8'b0000_0010);
    tick(1);
    check("to_at_limit", {7'b0, err_timeout}, 8'd1);
    tick(45);
    check("to_sticky", {7'b0, err_timeout}, 8'd1);
    rc = 2'b00;
    rm = 2'b00;
    wait_ack(1'b0, 20, "to_null_return");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("to_clr", {7'b0, err_timeout}, 8'd0);

    // Reset with a held token and DATA still on the rails
    sink_mode = 1;
    apply_data(1'b1, 1'b1, 1'b1, 0, 1'b0);
    wait_valid(20, "rst_valid");
    rst = 1'b1;
    tick(1);
    check("rst_mid", {6'b0, out_valid, ack_out}, 8'b0000_0001);
    exp_q.delete();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_valid || !ack_out) seen = 1'b1;
    end
    check("rst_no_capture", {7'b0, seen}, 8'd0);
    rc = 2'b00;
    rm = 2'b00;
    wait_ack(1'b0, 20, "rst_flush_exit");
    sink_mode = 0;
    apply_data(1'b0, 1'b1, 1'b0, 3, 1'b0);
    finish_token(1'b0, 1);
    sink_mode = 2;
    wait_drain(50, "final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
